// File: rtl/dds_rot_pkg.sv
// Shared types and constants for the rotary-encoder front-end of the
// function generator: quadrature FSM states, step-size selection and
// the step table.
package dds_rot_pkg;

    // Quadrature decoder states: one chain per rotation direction
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CW1  = 3'd1,
        CW2  = 3'd2,
        CW3  = 3'd3,
        CCW1 = 3'd4,
        CCW2 = 3'd5,
        CCW3 = 3'd6
    } rot_state_t;

    // Step-size selector as seen on the Step_sel output
    typedef enum logic [1:0] {
        STEP_SEL_1  = 2'd0,
        STEP_SEL_8  = 2'd1,
        STEP_SEL_64 = 2'd2
    } step_sel_t;

    // Step table; STEP_W bits hold the largest step
    localparam int         STEP_W     = 7;
    localparam logic [6:0] STEP_SMALL = 7'd1;
    localparam logic [6:0] STEP_MED   = 7'd8;
    localparam logic [6:0] STEP_LARGE = 7'd64;

    // Map a selector to its address increment
    function automatic logic [STEP_W-1:0] step_size(input step_sel_t sel);
        logic [STEP_W-1:0] s;
        case (sel)
            STEP_SEL_1:  s = STEP_SMALL;
            STEP_SEL_8:  s = STEP_MED;
            STEP_SEL_64: s = STEP_LARGE;
            default:     s = STEP_SMALL;
        endcase
        return s;
    endfunction

    // Push-button cycling order 0 -> 1 -> 2 -> 0
    function automatic step_sel_t next_step_sel(input step_sel_t sel);
        step_sel_t n;
        case (sel)
            STEP_SEL_1:  n = STEP_SEL_8;
            STEP_SEL_8:  n = STEP_SEL_64;
            default:     n = STEP_SEL_1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rot_debounce.sv
// Two-flop synchroniser followed by a stability filter for one raw
// encoder line. The filtered output only follows the synchronised value
// after it has differed for DEB_CYCLES consecutive cycles.
module rot_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic filt_o
);

    // Counter wraps the filter on the cycle it would reach DEB_CYCLES
    localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       filt_q;
    logic       filt_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Metastability synchroniser; idles high like the encoder lines
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing cycles; accept the new level on the last
    always_comb begin
        filt_d = filt_q;
        cnt_d  = 8'd0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    // Filter state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_q <= 1'b1;
            cnt_q  <= 8'd0;
        end else begin
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/rot_quad_decoder.sv
// Rotary-encoder front-end: debounced quadrature lines drive a detent
// decoder whose up/down steps move a saturating table address. One saved
// address per waveform mode is swapped in when the mode changes.
module rot_quad_decoder
    import dds_rot_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int ADDR_MAX   = 2047,
    parameter int DEB_CYCLES = 4,
    parameter int N_MODES    = 5,
    parameter int RESET_ADDR = 0
) (
    input  logic              Fg_clk,
    input  logic              Reset,
    input  logic              Rot_A,
    input  logic              Rot_B,
    input  logic              Rot_Push,
    input  logic [2:0]        Mode,
    output logic [ADDR_W-1:0] address,
    output logic [1:0]        Step_sel,
    output logic              FreqChng
);

    localparam logic [ADDR_W:0]   ADDR_MAX_W   = (ADDR_W+1)'(ADDR_MAX);
    localparam logic [ADDR_W-1:0] ADDR_MAX_A   = ADDR_MAX_W[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] RESET_ADDR_W = ADDR_W'(RESET_ADDR);
    localparam logic [3:0]        MODE_LIM     = 4'(N_MODES);

    // Saturating increment, evaluated one bit wider than the address
    function automatic logic [ADDR_W-1:0] sat_up(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W:0]   s);
        logic [ADDR_W:0] sum;
        sum = {1'b0, a} + s;
        if (sum > ADDR_MAX_W) begin
            return ADDR_MAX_A;
        end
        return sum[ADDR_W-1:0];
    endfunction

    // Decrement clamped at zero; the sign bit of the wide result flags underflow
    function automatic logic [ADDR_W-1:0] sat_dn(input logic [ADDR_W-1:0] a,
                                                 input logic [ADDR_W:0]   s);
        logic signed [ADDR_W:0] diff;
        diff = $signed({1'b0, a}) - $signed(s);
        if (diff < 0) begin
            return '0;
        end
        return diff[ADDR_W-1:0];
    endfunction

    logic              a_filt;
    logic              b_filt;
    logic [1:0]        ab;

    rot_state_t        state_q;
    rot_state_t        state_d;
    logic              up_q;
    logic              up_d;
    logic              dn_q;
    logic              dn_d;

    step_sel_t         step_sel_q;
    logic [ADDR_W:0]   step_ext;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              upd_q;
    logic              upd_d;
    logic              fc_q;
    logic [2:0]        mode_q;
    logic [2:0]        mode_d;
    logic              mode_ok;
    logic              mode_chg;
    logic [ADDR_W-1:0] slot_q [N_MODES];

    rot_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk_i  (Fg_clk),
        .rst_i  (Reset),
        .raw_i  (Rot_A),
        .filt_o (a_filt)
    );

    rot_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
        .clk_i  (Fg_clk),
        .rst_i  (Reset),
        .raw_i  (Rot_B),
        .filt_o (b_filt)
    );

    assign ab = {a_filt, b_filt};

    // Detent decoder: a step is only emitted when a full chain returns to 11
    always_comb begin
        state_d = state_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ab == 2'b10)      state_d = CW1;
                else if (ab == 2'b01) state_d = CCW1;
            end
            CW1: begin
                if (ab == 2'b00)      state_d = CW2;
                else if (ab == 2'b11) state_d = IDLE;
            end
            CW2: begin
                if (ab == 2'b01)      state_d = CW3;
                else if (ab == 2'b10) state_d = CW1;
                else if (ab == 2'b11) state_d = IDLE;
            end
            CW3: begin
                if (ab == 2'b11) begin
                    state_d = IDLE;
                    up_d    = 1'b1;
                end else if (ab == 2'b00) begin
                    state_d = CW2;
                end
            end
            CCW1: begin
                if (ab == 2'b00)      state_d = CCW2;
                else if (ab == 2'b11) state_d = IDLE;
            end
            CCW2: begin
                if (ab == 2'b10)      state_d = CCW3;
                else if (ab == 2'b01) state_d = CCW1;
                else if (ab == 2'b11) state_d = IDLE;
            end
            CCW3: begin
                if (ab == 2'b11) begin
                    state_d = IDLE;
                    dn_d    = 1'b1;
                end else if (ab == 2'b00) begin
                    state_d = CCW2;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Decoder state and registered step pulses
    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            state_q <= IDLE;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            up_q    <= up_d;
            dn_q    <= dn_d;
        end
    end

    // Step size cycles on each push; a coincident step still sees the old size
    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            step_sel_q <= STEP_SEL_1;
        end else if (Rot_Push) begin
            step_sel_q <= next_step_sel(step_sel_q);
        end
    end

    assign step_ext = {{(ADDR_W+1-STEP_W){1'b0}}, step_size(step_sel_q)};

    // Out-of-range modes are ignored entirely
    assign mode_ok  = ({1'b0, Mode} < MODE_LIM);
    assign mode_chg = mode_ok && (Mode != mode_q);

    // Next address: a mode swap takes priority over and discards any step
    always_comb begin
        addr_d = addr_q;
        upd_d  = 1'b0;
        mode_d = mode_q;
        if (mode_chg) begin
            addr_d = slot_q[Mode];
            upd_d  = 1'b1;
            mode_d = Mode;
        end else if (up_q) begin
            addr_d = sat_up(addr_q, step_ext);
            upd_d  = (addr_d != addr_q);
        end else if (dn_q) begin
            addr_d = sat_dn(addr_q, step_ext);
            upd_d  = (addr_d != addr_q);
        end
    end

    // Address, mode and strobe registers; FreqChng trails the address by one cycle
    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            addr_q <= RESET_ADDR_W;
            mode_q <= 3'd0;
            upd_q  <= 1'b0;
            fc_q   <= 1'b0;
        end else begin
            addr_q <= addr_d;
            mode_q <= mode_d;
            upd_q  <= upd_d;
            fc_q   <= upd_q;
        end
    end

    // Save the outgoing mode's address when switching modes
    always_ff @(posedge Fg_clk) begin
        if (Reset) begin
            for (int i = 0; i < N_MODES; i++) begin
                slot_q[i] <= RESET_ADDR_W;
            end
        end else if (mode_chg) begin
            slot_q[mode_q] <= addr_q;
        end
    end

    assign address  = addr_q;
    assign Step_sel = step_sel_q;
    assign FreqChng = fc_q;

endmodule

// File: doc/rot_quad_decoder.md
# rot_quad_decoder

Front-end for the function generator's frequency control. It synchronises and debounces the raw rotary-encoder quadrature lines and decodes full detents into up/down steps. It accumulates an ADDR_W-bit coefficient-table address with selectable step size and keeps one address per waveform mode. Its outputs are `address` and a one-cycle `FreqChng` strobe, which go to the coefficient table and the oscillator.

## Interface
- ADDR_W, 11: address width.
- ADDR_MAX, 2047: upper saturation limit of `address`.
- DEB_CYCLES, 4: consecutive stable cycles required before a filtered line changes; range 1..255.
- N_MODES, 5: number of per-mode address slots.
- RESET_ADDR, 0: reset value of `address` and of every slot.

Ports:
- Fg_clk  in  1  generator clock; all logic is on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Rot_A  in  1  raw encoder channel A; asynchronous; idles high.
- Rot_B  in  1  raw encoder channel B; asynchronous; idles high.
- Rot_Push  in  1  one-cycle pulse from the push-button debouncer; cycles the step size.
- Mode  in  3  current waveform mode from the sampling controller.
- address  out  ADDR_W  current table address.
- Step_sel  out  2  current step index (0, 1 or 2).
- FreqChng  out  1  one-cycle strobe marking a new `address` value.

## Operation
- **Synchronisers:** two flip-flops per channel; both stages reset to 1.
- **Debounce (per channel):**
  - The filtered value resets to 1.
  - A counter increments each cycle the synchronised value differs from the filtered value.
  - The counter clears on any cycle the two are equal.
  - When the counter reaches DEB_CYCLES, the filtered value takes the synchronised value and the counter clears.
- **Quadrature FSM on filtered {A,B}:**
  - States: IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3.
  - IDLE: 10 goes to CW1; 01 goes to CCW1; 00 stays in IDLE (illegal, no event).
  - Forward: CW1 on 00 goes to CW2; CW2 on 01 goes to CW3; CW3 on 11 returns to IDLE and emits an up step.
  - Reverse within a detent steps back one state: CW3 on 00 goes to CW2; CW2 on 10 goes to CW1.
  - CW1 or CW2 seeing 11 returns to IDLE with no event.
  - The CCW chain mirrors this: 01, then 00, then 10, then 11 emits a down step.
- **Step size:** Step_sel 0, 1, 2 selects a step of 1, 8, 64.
  - Each `Rot_Push` pulse advances Step_sel 0→1→2→0.
  - `Rot_Push` does not change `address`.
- **Accumulator:** computed at ADDR_W+1 bits.
  - Up step: address = min(address+step, ADDR_MAX).
  - Down step: address = max(address−step, 0).
  - If saturation leaves `address` unchanged, no FreqChng is issued.
- **Per-mode memory:**
  - `Mode` is registered. A change is detected when the registered value differs from the input.
  - On a change, the current `address` is written to the slot of the old mode, the slot of the new mode is loaded into `address`, and FreqChng is pulsed.
  - A `Mode` value ≥ N_MODES is ignored: the registered mode and `address` are held.
- **Simultaneous events:**
  - Step and push in the same cycle: the step uses the old step size, then Step_sel advances.
  - Mode change and step in the same cycle: the mode change wins and the step is dropped.
- **Reset:** applies in any state, including mid-detent.
  - Outputs: address = RESET_ADDR, Step_sel = 0, FreqChng = 0.
  - Internal: FSM to IDLE, filtered values to 1, counters to 0, all slots to RESET_ADDR, registered mode to 0.

## Timing
Edge counts below are measured from the Fg_clk edge that first samples a raw change.
- **Raw change to filtered value:**
  - The synchronised value is valid at edge 2.
  - The filtered value updates at edge 2+DEB_CYCLES, provided the raw input stays stable.
  - Pulses shorter than DEB_CYCLES cycles are rejected.
- **Final transition of a detent to output:** for the last transition (A rising for CW):
  - FSM state and step pulse update at edge 3+DEB_CYCLES.
  - `address` updates at edge 4+DEB_CYCLES.
  - FreqChng is high for exactly one cycle after that (edge 5+DEB_CYCLES).
- **Mode change:** `address` reloads one cycle after `Mode` changes; FreqChng follows one cycle later.
- **Throughput:** at most one step per detent. Back-to-back detents are limited only by the debounce time.

## Structure
- **Package `dds_rot_pkg`:**
  - enum `rot_state_t`: IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3.
  - Step table constants: 1, 8, 64.
  - Step_sel encoding.
- **Sub-module `rot_debounce`:** synchroniser, stability counter and filtered output; instantiated once for A and once for B, with parameter DEB_CYCLES.
- **Top level:** FSM, accumulator, slot array and mode-change logic.

## Test plan
- **Reset:** after Reset, address=0, Step_sel=0, FreqChng=0. Ten CW detents (B falls, A falls, B rises, A rises, 10 cycles apart) → address=10 and exactly ten FreqChng pulses, each at DEB_CYCLES+5 cycles after A rises.
- **Step sizes:** one push → Step_sel=1, three CW detents → address=24. Two more pushes → Step_sel=0. One CCW detent → address=23.
- **Saturation:** Step_sel=2, 40 CW detents → address=2047. Further CW detents give no FreqChng. Reset, then one CCW detent → address stays 0 with no FreqChng.
- **Glitch rejection:** a 2-cycle low pulse on Rot_B with DEB_CYCLES=4 → no FSM movement and no step. A partial CW sequence reversed (B falls, A falls, A rises, B rises) → no step.
- **Per-mode memory:**
  - Mode 0, address=10; switch to mode 1 → address=0 and FreqChng pulses.
  - Five CW detents → 5; back to mode 0 → address=10.
  - Mode=6 → address held, no FreqChng.
- **Collisions and reset mid-operation:** a step and a mode change in the same cycle → step dropped. Reset asserted at state CW2 → IDLE. The next full CW detent yields exactly one step.
